dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single data-memory port between two requesters: the pipeline memory stage (PIPE) and an auxiliary loader/debug port (AUX). Sequences each access against a variable-latency memory using a request/ready/rvalid handshake, and stalls the pipeline until its access completes. PIPE has priority, but a starvation counter guarantees AUX forward progress, and a timeout guarantees no access hangs forever. It sits between the memory-phase formatting logic (word-aligned addr, lane mask, lane-shifted wdata) and the data memory.

Parameters:
STARVE_LIMIT, 4, consecutive PIPE grants allowed while AUX waits before AUX is forced a grant (1..15)
TIMEOUT, 255, max cycles spent in ISSUE+WAIT before forced error completion; 0 disables (8-bit counter)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous reset, active-low
i_pipe_ren  in  1  PIPE load request, level, held stable while o_pipe_stall=1
i_pipe_wen  in  1  PIPE store request, level, held stable while o_pipe_stall=1
i_pipe_addr  in  32  word-aligned address
i_pipe_wdata  in  32  lane-shifted store data
i_pipe_mask  in  4  byte-lane mask
o_pipe_stall  out  1  hold pipeline
o_pipe_rdata  out  32  raw load word, valid only while o_pipe_done=1
o_pipe_done  out  1  one-cycle completion pulse
o_pipe_err  out  1  timeout flag, valid with o_pipe_done
i_aux_req  in  1  AUX request, level, held until o_aux_done
i_aux_we  in  1  1=write, 0=read
i_aux_addr  in  32  word address
i_aux_wdata  in  32  write data
i_aux_mask  in  4  byte-lane mask
o_aux_rdata  out  32  read word, valid with o_aux_done
o_aux_done  out  1  one-cycle completion pulse
o_aux_err  out  1  timeout flag, valid with o_aux_done
o_mem_req  out  1  memory request valid
o_mem_we  out  1  write enable
o_mem_addr  out  32  registered address
o_mem_wdata  out  32  registered write data
o_mem_mask  out  4  registered mask
i_mem_ready  in  1  memory accepts request (handshake when o_mem_req & i_mem_ready)
i_mem_rvalid  in  1  read data valid, never earlier than the cycle after acceptance
i_mem_rdata  in  32  read data

Behaviour:
- Reset: state=IDLE; starve_cnt=0; timeout counter=0; all outputs 0. A reset mid-access drops that access with no done pulse; memory is reset by the same signal.
- PIPE is requesting when i_pipe_ren|i_pipe_wen. If both are set, it is treated as a write.
- o_pipe_stall = PIPE requesting & ~o_pipe_done (combinational). It is low in the DONE cycle, when the pipeline advances.
- States:
  - IDLE: pick a winner, latch owner, we, addr, wdata and mask into registers, go to ISSUE. No request: stay in IDLE.
  - ISSUE: o_mem_req=1, memory outputs driven from the registers and stable. On i_mem_ready: a write goes to DONE, a read goes to WAIT.
  - WAIT: on i_mem_rvalid, capture i_mem_rdata and go to DONE.
  - DONE: pulse the owner's done for one cycle (rdata=captured word, 0 for writes). Then go to IDLE.
- PIPE requests are not sampled in DONE. A back-to-back PIPE access is granted at the earliest in the following IDLE cycle.
- Arbitration in IDLE:
  - Only one requester: it wins.
  - Both requesting: PIPE wins unless starve_cnt==STARVE_LIMIT, in which case AUX wins.
- starve_cnt update:
  - Increments (saturating) on each PIPE grant while i_aux_req=1.
  - Clears on an AUX grant or whenever i_aux_req=0 in IDLE.
- Latency (memory ready immediately):
  - Write: grant cycle 0, ISSUE 1, DONE 2.
  - Read with rvalid one cycle after acceptance: DONE at cycle 3.
- Timeout (TIMEOUT>0):
  - The counter clears on entry to ISSUE and increments in ISSUE and WAIT.
  - On reaching TIMEOUT: go to DONE with err=1 and rdata=0, deassert o_mem_req, and ignore any late rvalid.
- i_mem_rvalid outside WAIT is ignored.
- i_mem_ready is ignored when o_mem_req=0.
- Only one access is outstanding at any time.

Test Plan:
- PIPE store only (addr 0x100, wdata 0x0000AB00, mask 0010), ready immediate -> o_mem_req cycle 1 with registered fields, o_pipe_done cycle 2, stall high cycles 0-1, low cycle 2.
- PIPE load, ready immediate, rvalid cycle 2 with 0xDEADBEEF -> o_pipe_done cycle 3, o_pipe_rdata=0xDEADBEEF, o_pipe_err=0.
- PIPE continuous loads + AUX read held high, STARVE_LIMIT=4 -> exactly 4 PIPE completions, then 1 AUX grant, then PIPE resumes; starve_cnt returns to 0.
- Load with rvalid never arriving, TIMEOUT=8 -> o_pipe_done+o_pipe_err at ISSUE-entry+8 cycles, rdata=0; a late rvalid is ignored and the next access is correct.
- i_rst_n low in WAIT -> next cycle IDLE, all outputs 0, no done pulse; a post-reset AUX write completes normally.
- i_mem_ready held low 5 cycles in ISSUE -> o_mem_* stable for all 5 cycles, stall remains high, completes on acceptance.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the pipeline memory
// stage (PIPE) and an auxiliary loader/debug port (AUX). One access is
// outstanding at a time, sequenced IDLE -> ISSUE -> (WAIT) -> DONE.
// PIPE has priority, a starvation counter guarantees AUX progress, and a
// timeout forces an error completion if the memory never answers.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,   // 1..15
  parameter int TIMEOUT      = 255  // 0 disables, 8-bit counter
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pipe_ren,
  input  logic        i_pipe_wen,
  input  logic [31:0] i_pipe_addr,
  input  logic [31:0] i_pipe_wdata,
  input  logic [3:0]  i_pipe_mask,
  output logic        o_pipe_stall,
  output logic [31:0] o_pipe_rdata,
  output logic        o_pipe_done,
  output logic        o_pipe_err,
  input  logic        i_aux_req,
  input  logic        i_aux_we,
  input  logic [31:0] i_aux_addr,
  input  logic [31:0] i_aux_wdata,
  input  logic [3:0]  i_aux_mask,
  output logic [31:0] o_aux_rdata,
  output logic        o_aux_done,
  output logic        o_aux_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
  typedef enum logic {OWN_PIPE, OWN_AUX} owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);
  localparam bit         TMO_EN     = (TIMEOUT != 0);

  state_e      state_q,  state_d;
  owner_e      owner_q,  owner_d;
  logic        we_q,     we_d;
  logic [31:0] addr_q,   addr_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [3:0]  mask_q,   mask_d;
  logic [31:0] rdata_q,  rdata_d;
  logic        err_q,    err_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  tmo_q,    tmo_d;

  logic pipe_req;
  logic grant_aux;
  logic tmo_hit;
  logic pipe_done;
  logic aux_done;

  assign pipe_req  = i_pipe_ren | i_pipe_wen;
  assign pipe_done = (state_q == S_DONE) && (owner_q == OWN_PIPE);
  assign aux_done  = (state_q == S_DONE) && (owner_q == OWN_AUX);

  // Next-state, arbitration, starvation and timeout bookkeeping
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    starve_d  = starve_q;
    tmo_d     = tmo_q;
    grant_aux = 1'b0;
    tmo_hit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!i_aux_req) starve_d = '0;
        if (pipe_req || i_aux_req) begin
          grant_aux = i_aux_req && (!pipe_req || (starve_q == STARVE_LIM));
          state_d   = S_ISSUE;
          tmo_d     = '0;
          rdata_d   = '0;
          err_d     = 1'b0;
          if (grant_aux) begin
            owner_d  = OWN_AUX;
            we_d     = i_aux_we;
            addr_d   = i_aux_addr;
            wdata_d  = i_aux_wdata;
            mask_d   = i_aux_mask;
            starve_d = '0;
          end else begin
            owner_d = OWN_PIPE;
            we_d    = i_pipe_wen;   // ren & wen together is a store
            addr_d  = i_pipe_addr;
            wdata_d = i_pipe_wdata;
            mask_d  = i_pipe_mask;
            if (i_aux_req && (starve_q != 4'hF)) starve_d = starve_q + 4'd1;
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = tmo_q + 8'd1;
        tmo_hit = TMO_EN && (tmo_d == TMO_LIM);
        if (tmo_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (i_mem_ready) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d   = tmo_q + 8'd1;
        tmo_hit = TMO_EN && (tmo_d == TMO_LIM);
        if (tmo_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (i_mem_rvalid) begin
          state_d = S_DONE;
          rdata_d = i_mem_rdata;
        end
      end
      S_DONE: begin
        // Requests are not sampled here; the next grant happens in IDLE.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge i_clk) begin
    // NOTE: the datapath registers are reset too because they drive o_mem_* directly and must read 0 after reset.
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_PIPE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      starve_q <= '0;
      tmo_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
    end
  end

  assign o_mem_req    = (state_q == S_ISSUE);
  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_mask   = mask_q;

  assign o_pipe_stall = pipe_req & ~pipe_done;
  assign o_pipe_done  = pipe_done;
  assign o_pipe_rdata = pipe_done ? rdata_q : '0;
  assign o_pipe_err   = pipe_done & err_q;

  assign o_aux_done   = aux_done;
  assign o_aux_rdata  = aux_done ? rdata_q : '0;
  assign o_aux_err    = aux_done & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
// Inputs change 1 ns after each rising edge; outputs are checked there.
module tb_dmem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_pipe_ren, i_pipe_wen;
  logic [31:0] i_pipe_addr, i_pipe_wdata;
  logic [3:0]  i_pipe_mask;
  logic        o_pipe_stall;
  logic [31:0] o_pipe_rdata;
  logic        o_pipe_done, o_pipe_err;
  logic        i_aux_req, i_aux_we;
  logic [31:0] i_aux_addr, i_aux_wdata;
  logic [3:0]  i_aux_mask;
  logic [31:0] o_aux_rdata;
  logic        o_aux_done, o_aux_err;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready, i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_pipe_ren(i_pipe_ren), .i_pipe_wen(i_pipe_wen), .i_pipe_addr(i_pipe_addr),
    .i_pipe_wdata(i_pipe_wdata), .i_pipe_mask(i_pipe_mask),
    .o_pipe_stall(o_pipe_stall), .o_pipe_rdata(o_pipe_rdata),
    .o_pipe_done(o_pipe_done), .o_pipe_err(o_pipe_err),
    .i_aux_req(i_aux_req), .i_aux_we(i_aux_we), .i_aux_addr(i_aux_addr),
    .i_aux_wdata(i_aux_wdata), .i_aux_mask(i_aux_mask),
    .o_aux_rdata(o_aux_rdata), .o_aux_done(o_aux_done), .o_aux_err(o_aux_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  int          n_done;
  logic        seq [0:5];
  logic [31:0] aux_rd_seen;
  logic        early;

  initial begin
    i_rst_n = 1'b0;
    i_pipe_ren = 0; i_pipe_wen = 0; i_pipe_addr = '0; i_pipe_wdata = '0; i_pipe_mask = '0;
    i_aux_req = 0; i_aux_we = 0; i_aux_addr = '0; i_aux_wdata = '0; i_aux_mask = '0;
    i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    step(); step();

    // ---- reset state
    check("rst_mem_req",   32'(o_mem_req),   0);
    check("rst_mem_addr",  o_mem_addr,       0);
    check("rst_pipe_done", 32'(o_pipe_done), 0);
    check("rst_aux_done",  32'(o_aux_done),  0);
    check("rst_stall",     32'(o_pipe_stall), 0);
    i_rst_n = 1'b1;
    step();

    // ---- PIPE store, ready immediate: ISSUE cycle 1, DONE cycle 2
    i_pipe_wen = 1; i_pipe_addr = 32'h100; i_pipe_wdata = 32'h0000AB00; i_pipe_mask = 4'b0010;
    i_mem_ready = 1;
    #1;
    check("st_c0_stall", 32'(o_pipe_stall), 1);
    step();
    check("st_c1_req",   32'(o_mem_req),   1);
    check("st_c1_we",    32'(o_mem_we),    1);
    check("st_c1_addr",  o_mem_addr,       32'h100);
    check("st_c1_wdata", o_mem_wdata,      32'h0000AB00);
    check("st_c1_mask",  32'(o_mem_mask),  32'h2);
    check("st_c1_stall", 32'(o_pipe_stall), 1);
    step();
    check("st_c2_done",  32'(o_pipe_done), 1);
    check("st_c2_err",   32'(o_pipe_err),  0);
    check("st_c2_stall", 32'(o_pipe_stall), 0);
    check("st_c2_req",   32'(o_mem_req),   0);
    i_pipe_wen = 0;
    step();
    check("st_c3_done",  32'(o_pipe_done), 0);

    // ---- PIPE load, rvalid in cycle 2: DONE cycle 3
    i_pipe_ren = 1; i_pipe_addr = 32'h200; i_pipe_mask = 4'hF;
    step();
    check("ld_c1_req", 32'(o_mem_req), 1);
    check("ld_c1_we",  32'(o_mem_we),  0);
    step();
    i_mem_rvalid = 1; i_mem_rdata = 32'hDEADBEEF;
    check("ld_c2_req",   32'(o_mem_req),    0);
    check("ld_c2_stall", 32'(o_pipe_stall), 1);
    check("ld_c2_done",  32'(o_pipe_done),  0);
    step();
    check("ld_c3_done",  32'(o_pipe_done),  1);
    check("ld_c3_rdata", o_pipe_rdata,      32'hDEADBEEF);
    check("ld_c3_err",   32'(o_pipe_err),   0);
    check("ld_c3_stall", 32'(o_pipe_stall), 0);
    i_pipe_ren = 0; i_mem_rvalid = 0;
    step();

    // ---- Starvation: PIPE loads back-to-back, AUX read held
    i_pipe_ren = 1; i_pipe_addr = 32'h400;
    i_aux_req = 1; i_aux_we = 0; i_aux_addr = 32'h300; i_aux_mask = 4'hF;
    i_mem_ready = 1; i_mem_rvalid = 1; i_mem_rdata = 32'h12345678;
    n_done = 0; aux_rd_seen = '0;
    for (int c = 0; c < 80 && n_done < 6; c++) begin
      step();
      if (o_pipe_done) begin
        seq[n_done] = 1'b0;
        n_done++;
      end else if (o_aux_done) begin
        seq[n_done] = 1'b1;
        n_done++;
        aux_rd_seen = o_aux_rdata;
        i_aux_req = 0;
      end
    end
    i_pipe_ren = 0; i_mem_rvalid = 0;
    check("sv_completions", n_done, 6);
    if (n_done == 6) begin
      for (int k = 0; k < 6; k++)
        check($sformatf("sv_owner%0d", k), 32'(seq[k]), (k == 4) ? 32'd1 : 32'd0);
    end
    check("sv_aux_rdata", aux_rd_seen, 32'h12345678);
    step();
    check("sv_starve_clr", 32'(dut.starve_q), 0);

    // ---- Timeout: load accepted, rvalid never arrives; DONE at ISSUE-entry+8
    i_pipe_ren = 1; i_pipe_addr = 32'h500;
    early = 0;
    step();  // cycle 1: ISSUE entry
    for (int k = 0; k < 7; k++) begin
      if (o_pipe_done) early = 1;
      step();
    end      // now cycle 8
    if (o_pipe_done) early = 1;
    check("to_no_early", 32'(early),        0);
    check("to_c8_stall", 32'(o_pipe_stall), 1);
    step();  // cycle 9
    check("to_done",  32'(o_pipe_done),  1);
    check("to_err",   32'(o_pipe_err),   1);
    check("to_rdata", o_pipe_rdata,      0);
    check("to_req",   32'(o_mem_req),    0);
    i_pipe_ren = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hBAD0BAD0;  // late rvalid
    step();
    check("to_late_done", 32'(o_pipe_done), 0);
    i_mem_rvalid = 0;
    i_pipe_ren = 1; i_pipe_addr = 32'h504;
    step();
    step();
    i_mem_rvalid = 1; i_mem_rdata = 32'hCAFEF00D;
    step();
    check("to_next_done",  32'(o_pipe_done), 1);
    check("to_next_rdata", o_pipe_rdata,     32'hCAFEF00D);
    check("to_next_err",   32'(o_pipe_err),  0);
    i_pipe_ren = 0; i_mem_rvalid = 0;
    step();

    // ---- Reset in WAIT drops the AUX read with no done pulse
    i_aux_req = 1; i_aux_we = 0; i_aux_addr = 32'h700;
    step();  // ISSUE
    step();  // WAIT
    check("rw_in_wait", 32'(o_mem_req), 0);
    i_rst_n = 0; i_aux_req = 0;
    step();
    check("rw_req",       32'(o_mem_req),    0);
    check("rw_aux_done",  32'(o_aux_done),   0);
    check("rw_pipe_done", 32'(o_pipe_done),  0);
    check("rw_addr",      o_mem_addr,        0);
    check("rw_we",        32'(o_mem_we),     0);
    check("rw_aux_rdata", o_aux_rdata,       0);
    check("rw_stall",     32'(o_pipe_stall), 0);
    i_rst_n = 1;
    step();
    i_aux_req = 1; i_aux_we = 1; i_aux_addr = 32'h800; i_aux_wdata = 32'h11223344; i_aux_mask = 4'hF;
    step();
    check("aw_c1_req",   32'(o_mem_req), 1);
    check("aw_c1_we",    32'(o_mem_we),  1);
    check("aw_c1_addr",  o_mem_addr,     32'h800);
    check("aw_c1_wdata", o_mem_wdata,    32'h11223344);
    step();
    check("aw_c2_done",  32'(o_aux_done), 1);
    check("aw_c2_err",   32'(o_aux_err),  0);
    check("aw_c2_rdata", o_aux_rdata,     0);
    i_aux_req = 0;
    step();

    // ---- ready held low 5 cycles in ISSUE
    i_mem_ready = 0;
    i_pipe_wen = 1; i_pipe_addr = 32'h900; i_pipe_wdata = 32'h5A5A5A5A; i_pipe_mask = 4'b1100;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("rl_c%0d_req", k),   32'(o_mem_req),    1);
      check($sformatf("rl_c%0d_addr", k),  o_mem_addr,        32'h900);
      check($sformatf("rl_c%0d_wdata", k), o_mem_wdata,       32'h5A5A5A5A);
      check($sformatf("rl_c%0d_mask", k),  32'(o_mem_mask),   32'hC);
      check($sformatf("rl_c%0d_stall", k), 32'(o_pipe_stall), 1);
    end
    step();  // cycle 6: still ISSUE, now accepted
    i_mem_ready = 1;
    check("rl_c6_req", 32'(o_mem_req), 1);
    step();
    check("rl_done",  32'(o_pipe_done),  1);
    check("rl_err",   32'(o_pipe_err),   0);
    check("rl_stall", 32'(o_pipe_stall), 0);
    i_pipe_wen = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
